// File: rtl/alien_line_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : alien_line_scheduler_pkg / alien_line_scheduler_if
// Description : Alien object record type and the bundle of timing, table and
//               renderer signals shared by the line scheduler and its
//               surroundings.
// Revision    : 1.0 - initial release
// ============================================================================

package alien_line_scheduler_pkg;

    // One alien table entry; r is the "distance" (smaller = nearer/larger),
    // the half extent on screen is 32 - r.
    typedef struct packed {
        logic [9:0] x_pos;
        logic [9:0] y_pos;
        logic [4:0] r;
    } AlienData;

endpackage : alien_line_scheduler_pkg

interface alien_line_scheduler_if #(
    parameter int MAX_ALIENS = 16
);
    import alien_line_scheduler_pkg::*;

    localparam int ADDR_W = $clog2(MAX_ALIENS);

    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic [ADDR_W:0]   alien_count;
    logic [ADDR_W-1:0] tbl_addr;
    AlienData          tbl_data;
    AlienData          obj_data;
    logic              obj_valid;
    logic              line_overflow;
    logic              scan_busy;

    // Timing generator / table / renderer side
    modport master (
        output h_cnt, v_cnt, alien_count, tbl_data,
        input  tbl_addr, obj_data, obj_valid, line_overflow, scan_busy
    );

    // Scheduler side
    modport slave (
        input  h_cnt, v_cnt, alien_count, tbl_data,
        output tbl_addr, obj_data, obj_valid, line_overflow, scan_busy
    );

endinterface : alien_line_scheduler_if
`default_nettype wire

// File: rtl/alien_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alien_line_scheduler
// Description : During horizontal blanking scans the alien table and latches
//               up to SLOTS aliens covering the next line into a back slot
//               list; at the start of each line the back list becomes the
//               front list, from which the nearest alien covering the current
//               pixel is selected and registered out to the renderer.
// Revision    : 1.0 - initial release
// ============================================================================

module alien_line_scheduler
    import alien_line_scheduler_pkg::*;
#(
    parameter int MAX_ALIENS = 16,
    parameter int SLOTS      = 4,
    parameter int H_ACTIVE   = 640,
    parameter int V_TOTAL    = 525
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    alien_line_scheduler_if.slave      sched_if
);

    localparam int          ADDR_W    = $clog2(MAX_ALIENS);
    localparam int          CNT_W     = ADDR_W + 1;
    localparam logic [9:0]  H_ACT_V   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LAST_V  = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              state_q;
    logic                busy_q;
    logic [9:0]          h_prev_q;
    logic [10:0]         line_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                eval_q;

    AlienData            back_q      [SLOTS];
    logic [SLOTS-1:0]    back_vld_q;
    logic                back_ovf_q;
    AlienData            front_q     [SLOTS];
    logic [SLOTS-1:0]    front_vld_q;
    logic                line_ovf_q;

    AlienData            obj_data_q;
    logic                obj_valid_q;

    // ------------------------------------------------------------------
    // Next-state / combinational signals
    // ------------------------------------------------------------------
    AlienData            back_d      [SLOTS];
    logic [SLOTS-1:0]    back_vld_d;
    logic                back_ovf_d;

    logic                w_start;
    logic                w_swap;
    logic [10:0]         w_next_line;
    logic                w_last;
    logic                w_qual;
    logic                w_placed;
    logic                w_hit;
    AlienData            w_best;

    // Half extent of an alien: nearer aliens (smaller r) are larger.
    function automatic logic [10:0] half_ext(input logic [4:0] r);
        return 11'd32 - {6'd0, r};
    endfunction

    // Coverage test along one axis with the low edge clamped at 0 (no wrap).
    function automatic logic covers(input logic [9:0] pos,
                                    input logic [4:0] r,
                                    input logic [10:0] p);
        logic [10:0] hh;
        logic [10:0] lo;
        logic [10:0] hi;
        hh = half_ext(r);
        lo = ({1'b0, pos} < hh) ? 11'd0 : ({1'b0, pos} - hh);
        hi = {1'b0, pos} + hh;
        return (lo <= p) && (p < hi);
    endfunction

    assign w_start     = (sched_if.h_cnt == H_ACT_V) && (h_prev_q != H_ACT_V);
    assign w_swap      = (sched_if.h_cnt == 10'd0)   && (h_prev_q != 10'd0);
    assign w_next_line = (sched_if.v_cnt == V_LAST_V) ? 11'd0
                                                      : ({1'b0, sched_if.v_cnt} + 11'd1);
    assign w_last      = ({1'b0, addr_q} == (sched_if.alien_count - CNT_W'(1)));
    assign w_qual      = eval_q && covers(sched_if.tbl_data.y_pos,
                                          sched_if.tbl_data.r, line_q);

    // Back list update: clear on scan start, otherwise place a qualifying
    // entry in the lowest free slot or flag overflow when the list is full.
    always_comb begin
        back_d     = back_q;
        back_vld_d = back_vld_q;
        back_ovf_d = back_ovf_q;
        w_placed   = 1'b0;
        if (w_start) begin
            back_vld_d = '0;
            back_ovf_d = 1'b0;
        end else if (w_qual) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (!w_placed && !back_vld_q[i]) begin
                    back_d[i]     = sched_if.tbl_data;
                    back_vld_d[i] = 1'b1;
                    w_placed      = 1'b1;
                end
            end
            if (!w_placed) begin
                back_ovf_d = 1'b1;
            end
        end
    end

    // Scan FSM, slot lists and the front/back swap at line start. The swap
    // uses the back list including the entry evaluated on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            h_prev_q    <= 10'd0;
            line_q      <= 11'd0;
            addr_q      <= '0;
            eval_q      <= 1'b0;
            back_vld_q  <= '0;
            back_ovf_q  <= 1'b0;
            front_vld_q <= '0;
            line_ovf_q  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
        end else begin
            h_prev_q   <= sched_if.h_cnt;
            back_q     <= back_d;
            back_vld_q <= back_vld_d;
            back_ovf_q <= back_ovf_d;

            if (w_swap) begin
                front_q     <= back_d;
                front_vld_q <= back_vld_d;
                line_ovf_q  <= back_ovf_d;
            end

            if (w_start) begin
                line_q <= w_next_line;
                addr_q <= '0;
                eval_q <= 1'b0;
                if (sched_if.alien_count != '0) begin
                    state_q <= S_SCAN;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            end else if (w_swap) begin
                eval_q  <= 1'b0;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_SCAN: begin
                        eval_q <= 1'b1;
                        if (w_last) begin
                            state_q <= S_DRAIN;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        eval_q  <= 1'b0;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        eval_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Nearest-alien search over the front list; ties go to the lower slot.
    always_comb begin
        w_hit  = 1'b0;
        w_best = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (front_vld_q[i] &&
                covers(front_q[i].x_pos, front_q[i].r, {1'b0, sched_if.h_cnt})) begin
                if (!w_hit || (front_q[i].r < w_best.r)) begin
                    w_best = front_q[i];
                    w_hit  = 1'b1;
                end
            end
        end
    end

    // Registered renderer output; data holds when nothing covers the pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            obj_data_q  <= '0;
            obj_valid_q <= 1'b0;
        end else if (sched_if.h_cnt >= H_ACT_V) begin
            obj_valid_q <= 1'b0;
        end else if (w_hit) begin
            obj_data_q  <= w_best;
            obj_valid_q <= 1'b1;
        end else begin
            obj_valid_q <= 1'b0;
        end
    end

    assign sched_if.tbl_addr      = addr_q;
    assign sched_if.obj_data      = obj_data_q;
    assign sched_if.obj_valid     = obj_valid_q;
    assign sched_if.line_overflow = line_ovf_q;
    assign sched_if.scan_busy     = busy_q;

endmodule : alien_line_scheduler
`default_nettype wire

// File: tb/tb_alien_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alien_line_scheduler
// Description : Directed scenarios for alien_line_scheduler with an
//               expectation queue popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_alien_line_scheduler;
    import alien_line_scheduler_pkg::*;

    localparam int K_OBJ  = 0;
    localparam int K_VLD  = 1;
    localparam int K_OVF  = 2;
    localparam int K_BUSY = 3;
    localparam int K_ADDR = 4;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    alien_line_scheduler_if #(.MAX_ALIENS(16)) bus ();

    alien_line_scheduler #(
        .MAX_ALIENS (16),
        .SLOTS      (4),
        .H_ACTIVE   (640),
        .V_TOTAL    (525)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (bus)
    );

    AlienData tbl [16];

    // Synchronous-read alien table
    always @(posedge clk) bus.tbl_data <= tbl[bus.tbl_addr];

    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    exp_t        m_e;
    logic [31:0] m_act;

    function automatic AlienData mk(input int x, input int y, input int r);
        AlienData a;
        a.x_pos = 10'(x);
        a.y_pos = 10'(y);
        a.r     = 5'(r);
        return a;
    endfunction

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_OBJ:   return {6'd0, bus.obj_valid, bus.obj_data};
            K_VLD:   return {31'd0, bus.obj_valid};
            K_OVF:   return {31'd0, bus.line_overflow};
            K_BUSY:  return {31'd0, bus.scan_busy};
            default: return {28'd0, bus.tbl_addr};
        endcase
    endfunction

    // Monitor: compare every expectation whose cycle has come
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            m_e   = sbq.pop_front();
            m_act = actual(m_e.kind);
            total++;
            if (m_e.due != cyc || m_act !== m_e.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h (cycle %0d)",
                         m_e.name, m_act, m_e.exp, cyc);
            end
        end
    end

    task automatic push(input int kind, input logic [31:0] e, input string nm,
                        input int dly);
        exp_t x;
        x.due  = cyc + dly;
        x.kind = kind;
        x.exp  = e;
        x.name = nm;
        sbq.push_back(x);
    endtask

    task automatic set_hv(input int h, input int v);
        @(negedge clk);
        bus.h_cnt = 10'(h);
        bus.v_cnt = 10'(v);
    endtask

    // Present pixel h and expect {valid, data} one clock later
    task automatic pix(input int h, input int v, input logic vld,
                       input AlienData d, input string nm);
        set_hv(h, v);
        push(K_OBJ, {6'd0, vld, d}, nm, 1);
    endtask

    // Full scan (abort_k == 0) or swap abort_k clocks after start_evt
    task automatic do_scan(input int vstart, input int vnext, input int n,
                           input int abort_k, input logic exp_ovf,
                           input string tag);
        bus.alien_count = 5'(n);
        set_hv(639, vstart);
        set_hv(640, vstart);
        push(K_BUSY, 32'd1, {tag, "_busy_start"}, 1);
        push(K_ADDR, 32'd0, {tag, "_addr0"}, 1);
        if (abort_k == 0) begin
            if (n >= 3) push(K_ADDR, 32'd2, {tag, "_addr2"}, 3);
            push(K_BUSY, 32'd1, {tag, "_busy_drain"}, n + 1);
            push(K_BUSY, 32'd0, {tag, "_busy_done"},  n + 2);
            repeat (n + 3) set_hv(700, vstart);
        end else begin
            repeat (abort_k - 1) set_hv(700, vstart);
        end
        set_hv(0, vnext);
        push(K_OVF, {31'd0, exp_ovf}, {tag, "_overflow"}, 1);
        if (abort_k != 0) push(K_BUSY, 32'd0, {tag, "_busy_abort"}, 1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.h_cnt       = 10'd0;
        bus.v_cnt       = 10'd0;
        bus.alien_count = 5'd0;
        for (int i = 0; i < 16; i++) tbl[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        push(K_OBJ,  32'd0, "rst_obj",  1);
        push(K_OVF,  32'd0, "rst_ovf",  1);
        push(K_BUSY, 32'd0, "rst_busy", 1);
        push(K_ADDR, 32'd0, "rst_addr", 1);
        @(negedge clk);
        total++;
        if (bus.obj_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_direct_vld: got %b expected 0", bus.obj_valid);
        end
        total++;
        if (bus.line_overflow !== 1'b0) begin
            bad++;
            $display("FAIL rst_direct_ovf: got %b expected 0", bus.line_overflow);
        end
        total++;
        if (bus.scan_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_direct_busy: got %b expected 0", bus.scan_busy);
        end
        total++;
        if (bus.tbl_addr !== 4'd0) begin
            bad++;
            $display("FAIL rst_direct_addr: got %h expected 0", bus.tbl_addr);
        end
        rst = 1'b0;

        // 1: basic selection, L = 100
        tbl[0] = mk(200, 100, 16);
        tbl[1] = mk(50, 300, 0);
        tbl[2] = mk(210, 110, 8);
        do_scan(99, 100, 3, 0, 1'b0, "t1");
        pix(205, 100, 1'b1, tbl[2], "t1_h205_C");
        pix(190, 100, 1'b1, tbl[2], "t1_h190_C");
        pix(184, 100, 1'b1, tbl[0], "t1_h184_A");
        pix(183, 100, 1'b0, tbl[0], "t1_h183_hold");
        pix(216, 100, 1'b1, tbl[2], "t1_h216_C");
        pix(233, 100, 1'b1, tbl[2], "t1_h233_C");
        pix(234, 100, 1'b0, tbl[2], "t1_h234_hold");
        pix(400, 100, 1'b0, tbl[2], "t1_h400_none");

        // 2: overflow, six aliens on line 240
        for (int i = 0; i < 6; i++) tbl[i] = mk(100 + 50 * i, 240, 10);
        do_scan(239, 240, 6, 0, 1'b1, "t2");
        pix(100, 240, 1'b1, tbl[0], "t2_slot0");
        pix(250, 240, 1'b1, tbl[3], "t2_slot3");
        pix(150, 240, 1'b1, tbl[1], "t2_slot1");
        pix(200, 240, 1'b1, tbl[2], "t2_slot2");
        pix(300, 240, 1'b0, tbl[2], "t2_entry4_dropped");
        for (int i = 2; i < 6; i++) tbl[i] = mk(100 + 50 * i, 450, 10);
        do_scan(240, 241, 6, 0, 1'b0, "t2b");
        pix(150, 241, 1'b1, tbl[1], "t2b_slot1");
        pix(200, 241, 1'b0, tbl[1], "t2b_entry2_out");

        // 3+4: tie, top clamp and line wrap (v_cnt = 524 -> L = 0)
        tbl[0] = mk(5, 5, 20);
        tbl[1] = mk(6, 5, 20);
        tbl[2] = mk(5, 1010, 19);
        tbl[3] = mk(5, 530, 19);
        do_scan(524, 0, 4, 0, 1'b0, "t3");
        pix(0,  0, 1'b1, tbl[0], "t3_tie_h0");
        pix(16, 0, 1'b1, tbl[0], "t3_tie_h16");
        pix(17, 0, 1'b1, tbl[1], "t3_h17_slot1");
        pix(18, 0, 1'b0, tbl[1], "t3_h18_none");

        // 5: scan aborted by a swap five clocks after start
        for (int i = 0; i < 16; i++) tbl[i] = mk(630, 50, (i < 3) ? 5 : ((i == 3) ? 3 : 1));
        do_scan(49, 50, 16, 5, 1'b0, "t5");
        pix(635, 50, 1'b1, tbl[3], "t5_entry3");
        set_hv(645, 50);
        push(K_VLD, 32'd0, "t5_blank_invalid", 1);
        set_hv(650, 50);
        push(K_BUSY, 32'd0, "t5_idle", 1);

        // 6: full overflowing scan, then reset in the middle of the next scan
        do_scan(49, 50, 16, 0, 1'b1, "t6");
        pix(635, 50, 1'b1, tbl[3], "t6_entry3");
        set_hv(639, 49);
        set_hv(640, 49);
        set_hv(700, 49);
        push(K_BUSY, 32'd1, "t6_midscan_busy", 1);
        set_hv(700, 49);
        rst = 1'b1;
        push(K_OBJ,  32'd0, "t6_rst_obj",  1);
        push(K_OVF,  32'd0, "t6_rst_ovf",  1);
        push(K_BUSY, 32'd0, "t6_rst_busy", 1);
        push(K_ADDR, 32'd0, "t6_rst_addr", 1);
        @(negedge clk);
        total++;
        if (bus.scan_busy !== 1'b0) begin
            bad++;
            $display("FAIL t6_direct_busy: got %b expected 0", bus.scan_busy);
        end
        total++;
        if (bus.tbl_addr !== 4'd0) begin
            bad++;
            $display("FAIL t6_direct_addr: got %h expected 0", bus.tbl_addr);
        end
        total++;
        if (bus.line_overflow !== 1'b0) begin
            bad++;
            $display("FAIL t6_direct_ovf: got %b expected 0", bus.line_overflow);
        end
        rst = 1'b0;
        pix(0,   50, 1'b0, '0, "t6_line_h0");
        pix(100, 50, 1'b0, '0, "t6_line_h100");
        pix(635, 50, 1'b0, '0, "t6_line_h635");

        // Drain the expectation queue with a bounded wait
        for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        while (sbq.size() > 0) begin
            m_e = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never checked, expected %h", m_e.name, m_e.exp);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_alien_line_scheduler
`default_nettype wire

// File: doc/alien_line_scheduler.md
Name: alien_line_scheduler

Overview:
- Upstream feeder of the alien renderer.
- During horizontal blanking of each line, scans the alien object table and latches up to SLOTS aliens that vertically cover the next line into a double-buffered slot list.
- During the displayed line, selects per pixel the nearest alien horizontally covering h_cnt.
- Presents that alien as obj_data/obj_valid to the renderer.

Parameters:
MAX_ALIENS, 16, table depth; tbl_addr width = clog2(MAX_ALIENS)
SLOTS, 4, aliens held per line
H_ACTIVE, 640, first blanking h_cnt value (scan trigger)
V_TOTAL, 525, line count per frame (next-line wrap)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
h_cnt  in  10  current pixel column from VGA timing
v_cnt  in  10  current line from VGA timing
alien_count  in  clog2(MAX_ALIENS)+1  live table entries; entries 0..alien_count-1 are scanned
tbl_addr  out  clog2(MAX_ALIENS)  alien table read address; synchronous read, data valid 1 clk later
tbl_data  in  AlienData  table read data
obj_data  out  AlienData  selected alien for renderer
obj_valid  out  1  obj_data covers current pixel
line_overflow  out  1  more than SLOTS aliens qualified for the line now displayed
scan_busy  out  1  scan FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM IDLE; both slot lists empty (all slot-valid bits 0).
- Extents: hh = 32 - _r (11-bit unsigned).
  - Vertical cover of line L: top = (_y_pos < hh) ? 0 : _y_pos - hh; top <= L < _y_pos + hh.
  - Horizontal cover of h: x_pos - hh <= h < x_pos + hh, same clamp at 0. All compares are 11-bit, with no wrap.
- Edge detect: h_prev register. start_evt when h_cnt == H_ACTIVE && h_prev != H_ACTIVE. swap_evt when h_cnt == 0 && h_prev != 0.
- Target line: L = (v_cnt == V_TOTAL-1) ? 0 : v_cnt+1, latched at start_evt.
- FSM, scan phase:
  - IDLE -> SCAN on start_evt if alien_count != 0; otherwise the back list is cleared and the FSM stays IDLE.
  - Start of scan: back list cleared; back overflow cleared.
  - SCAN: tbl_addr increments 0..alien_count-1, one per clk. tbl_data is evaluated the following clk, so the pipeline uses a valid bit delayed by 1.
  - A qualifying entry goes into the lowest free back slot, keeping table order. If all slots are full, the entry is dropped and back overflow is set.
  - SCAN -> DRAIN after the last address is issued.
- FSM, drain and swap:
  - DRAIN: evaluate the final entry -> DONE.
  - DONE: wait for swap_evt -> IDLE.
  - On swap_evt, in any state: back list and overflow copy to front, and line_overflow updates.
  - If swap_evt arrives while in SCAN/DRAIN, the partial list is swapped, the scan aborts, and the FSM goes to IDLE.
- start_evt while not IDLE: restarts the scan with the new L.
- Scan latency: alien_count+2 clk from start_evt to DONE.
- Selection, every clk, over front slots:
  - Candidates are valid slots with horizontal cover of h_cnt.
  - The winner has the smallest _r (nearest). On a tie, the lowest slot index wins.
  - Registered: obj_data = winner and obj_valid = 1 one clk after h_cnt is presented.
  - With no candidate: obj_valid = 0, obj_data holds its previous value.
  - When h_cnt >= H_ACTIVE: obj_valid = 0.
- rst mid-scan: immediate return to reset state; tbl_addr = 0.
- scan_busy = 1 in SCAN and DRAIN only.

Test Plan:
1. Setup: alien_count=3; aliens
   - A: y=100, r=16, x=200
   - B: y=300, r=0, x=50
   - C: y=110, r=8, x=210
   Stimulus: v_cnt=99, start_evt, then swap_evt.
   Expected: front = {A, C}; at h_cnt=205 obj_data = C (r=8 < 16), obj_valid=1; at h_cnt=400 obj_valid=0.
2. Overflow: 6 aliens all at y=240, r=10; scan line 240.
   Expected: slots hold entries 0-3; line_overflow=1 after swap; next line with 2 qualifying aliens gives line_overflow=0.
3. Tie and clamp: two aliens with r=20, x=5, y=5.
   Expected: at h_cnt=0, v line 0, obj_data = slot 0; clamp yields top=0 with no wrap to line 1000.
4. Wrap: v_cnt=524 at start_evt.
   Expected: L=0 and only aliens covering line 0 are loaded.
5. Aborted scan: alien_count=16, swap_evt 5 clk after start_evt.
   Expected: only entries 0..3 are evaluated; scan_busy drops; FSM is in IDLE.
6. Reset: rst asserted mid-SCAN.
   Expected: next clk all outputs 0, tbl_addr=0, obj_valid=0 for the whole following line.
